// File: rtl/control_pkg.sv
// Shared constants and types for the instruction-sequencing controller:
// opcode map, ALU operation codes, PC-select encodings, FSM states and
// the instruction classes produced by the decoder.
package control_pkg;

  // Opcode map (4-bit instruction opcode field)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SFT  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_LIM  = 4'd4;
  localparam logic [3:0] OP_MVB  = 4'd5;
  localparam logic [3:0] OP_MVF  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BLT  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_LB   = 4'd11;
  localparam logic [3:0] OP_LHB  = 4'd12;
  localparam logic [3:0] OP_STR  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_TBA  = 4'd15;

  // ALU operation codes (zero-extended to the alu_inst width)
  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_SFT_L = 4'd2;
  localparam logic [3:0] ALUOP_SFT_R = 4'd3;
  localparam logic [3:0] ALUOP_INC   = 4'd4;
  localparam logic [3:0] ALUOP_DEC   = 4'd5;
  localparam logic [3:0] ALUOP_BNE   = 4'd6;
  localparam logic [3:0] ALUOP_BEQ   = 4'd7;
  localparam logic [3:0] ALUOP_BLT   = 4'd8;
  localparam logic [3:0] ALUOP_NONE  = 4'd0;

  // PC source selection
  localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_HALT,
    CLS_TRAP
  } iclass_t;

  // True for classes that need a data-memory transaction after EXECUTE
  function automatic logic uses_data_mem(input iclass_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: maps the captured opcode and
// immediate flag to an ALU operation code and an instruction class.
module control_decode
  import control_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_flag,
  output logic [3:0] alu_op,
  output iclass_t    iclass
);

  // Opcode table; opcodes without an ALU role report ALUOP_NONE
  always_comb begin
    alu_op = ALUOP_NONE;
    iclass = CLS_TRAP;
    case (opcode)
      OP_ADD:  begin alu_op = ALUOP_ADD; iclass = CLS_ALU; end
      OP_SUB:  begin alu_op = ALUOP_SUB; iclass = CLS_ALU; end
      // imm_flag picks shift direction (1 = right)
      OP_SFT:  begin alu_op = imm_flag ? ALUOP_SFT_R : ALUOP_SFT_L; iclass = CLS_ALU; end
      // imm_flag picks increment (1) or decrement (0)
      OP_INC:  begin alu_op = imm_flag ? ALUOP_INC : ALUOP_DEC; iclass = CLS_ALU; end
      OP_LIM:  iclass = CLS_ALU;
      OP_MVB:  iclass = CLS_ALU;
      OP_MVF:  iclass = CLS_ALU;
      OP_BNE:  begin alu_op = ALUOP_BNE; iclass = CLS_BRANCH; end
      OP_BEQ:  begin alu_op = ALUOP_BEQ; iclass = CLS_BRANCH; end
      OP_BLT:  begin alu_op = ALUOP_BLT; iclass = CLS_BRANCH; end
      OP_JMP:  iclass = CLS_JUMP;
      OP_LB:   iclass = CLS_LOAD;
      OP_LHB:  iclass = CLS_LOAD;
      OP_STR:  iclass = CLS_STORE;
      OP_HALT: iclass = CLS_HALT;
      OP_TBA:  iclass = CLS_TRAP;
      default: iclass = CLS_TRAP;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory /
// writeback with a memory-wait timeout, halt and error recovery, and a
// retired-instruction counter.
module control_fsm
  import control_pkg::*;
#(
  parameter int ALU_W  = 4,
  parameter int CNT_W  = 16,
  parameter int MEM_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             imm_flag,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_req,
  output logic             ifetch,
  output logic             read_mem,
  output logic             write_mem,
  output logic             ir_load,
  output logic [ALU_W-1:0] alu_inst,
  output logic             write_reg,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  // Wait counter must hold values up to MEM_TO-1
  localparam int WAIT_W = $clog2(MEM_TO + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

  state_t            state_reg, state_next;
  logic [3:0]        opcode_reg;
  logic              imm_reg;
  iclass_t           iclass_reg;
  logic [ALU_W-1:0]  alu_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  retired_reg;
  logic              halt_entry;
  logic              retire;

  logic [3:0]        dec_alu;
  iclass_t           dec_class;

  control_decode u_decode (
    .opcode   (opcode_reg),
    .imm_flag (imm_reg),
    .alu_op   (dec_alu),
    .iclass   (dec_class)
  );

  // State register, wait counter and retired counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // Instruction register and latched decode results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_reg <= '0;
      imm_reg    <= 1'b0;
      iclass_reg <= CLS_ALU;
      alu_reg    <= '0;
    end else begin
      if (ir_load) begin
        opcode_reg <= opcode;
        imm_reg    <= imm_flag;
      end
      if (state_reg == ST_DECODE) begin
        iclass_reg <= dec_class;
        alu_reg    <= ALU_W'(dec_alu);
      end
    end
  end

  // Next-state and strobe generation; every output is forced low in reset
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    mem_req       = 1'b0;
    ifetch        = 1'b0;
    read_mem      = 1'b0;
    write_mem     = 1'b0;
    ir_load       = 1'b0;
    write_reg     = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = PC_SEL_NEXT;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    halt_entry    = 1'b0;

    if (reset) begin
      state_next = ST_FETCH;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ifetch   = 1'b1;
          read_mem = 1'b1;
          if (mem_ready) begin
            ir_load    = 1'b1;
            state_next = ST_DECODE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_next = ST_ERROR;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end

        ST_DECODE: begin
          state_next = ST_EXECUTE;
        end

        ST_EXECUTE: begin
          case (iclass_reg)
            CLS_ALU: state_next = ST_WRITEBACK;
            CLS_BRANCH: begin
              pc_en      = 1'b1;
              pc_sel     = branch_taken ? PC_SEL_BRANCH : PC_SEL_NEXT;
              state_next = ST_FETCH;
            end
            CLS_JUMP: begin
              pc_en      = 1'b1;
              pc_sel     = PC_SEL_JUMP;
              state_next = ST_FETCH;
            end
            CLS_HALT: begin
              halt_entry = 1'b1;
              state_next = ST_HALT;
            end
            CLS_TRAP: begin
              // Unknown instruction: flag it and step past it
              illegal_op = 1'b1;
              pc_en      = 1'b1;
              state_next = ST_FETCH;
            end
            default: begin
              if (uses_data_mem(iclass_reg)) begin
                state_next = ST_MEM;
              end else begin
                state_next = ST_FETCH;
              end
            end
          endcase
        end

        ST_MEM: begin
          mem_req   = 1'b1;
          read_mem  = (iclass_reg == CLS_LOAD);
          write_mem = (iclass_reg == CLS_STORE);
          if (mem_ready) begin
            if (iclass_reg == CLS_LOAD) begin
              state_next = ST_WRITEBACK;
            end else begin
              // Store completes here; nothing to write back
              pc_en      = 1'b1;
              state_next = ST_FETCH;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_next = ST_ERROR;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end

        ST_WRITEBACK: begin
          write_reg  = 1'b1;
          pc_en      = 1'b1;
          state_next = ST_FETCH;
        end

        ST_HALT: begin
          halted = 1'b1;
          if (resume) begin
            pc_en      = 1'b1;
            state_next = ST_FETCH;
          end
        end

        ST_ERROR: begin
          // Resume retries the same PC, so the PC is left untouched
          mem_timeout = 1'b1;
          if (resume) begin
            state_next = ST_FETCH;
          end
        end

        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

  assign retire   = pc_en | halt_entry;
  assign alu_inst = alu_reg;
  assign retired  = retired_reg;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus pushes expected observable
// events, a negedge monitor pops and compares whenever the DUT shows one.
module tb_control_fsm;
  import control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       imm_flag;
  logic       branch_taken;
  logic       mem_ready = 1'b0;
  logic       resume;
  logic       mem_req, ifetch, read_mem, write_mem, ir_load;
  logic [3:0] alu_inst;
  logic       write_reg, pc_en;
  logic [1:0] pc_sel;
  logic       halted, illegal_op, mem_timeout;
  logic [1:0] retired;

  control_fsm #(.ALU_W(4), .CNT_W(2), .MEM_TO(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .imm_flag     (imm_flag),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .mem_req      (mem_req),
    .ifetch       (ifetch),
    .read_mem     (read_mem),
    .write_mem    (write_mem),
    .ir_load      (ir_load),
    .alu_inst     (alu_inst),
    .write_reg    (write_reg),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .halted       (halted),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cyc;   // cycles since last ir_load (ir_load cycle = 1)
    logic       ir;
    logic       wreg;
    logic       pen;
    logic [1:0] sel;
    logic       ill;
    logic       hlt;
    logic       mto;
    logic [3:0] alu;
    logic [1:0] ret;
    logic [4:0] mcyc;  // data-memory request cycles since last ir_load
    logic       rd;
    logic       wr;
  } ev_t;

  ev_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  n_ev   = 0;

  function automatic ev_t mk(int cyc, int ir, int wreg, int pen, int sel, int ill,
                             int hlt, int mto, int alu, int ret, int mcyc, int rd, int wr);
    ev_t e;
    e.cyc  = 8'(cyc);  e.ir  = 1'(ir);  e.wreg = 1'(wreg); e.pen = 1'(pen);
    e.sel  = 2'(sel);  e.ill = 1'(ill); e.hlt  = 1'(hlt);  e.mto = 1'(mto);
    e.alu  = 4'(alu);  e.ret = 2'(ret); e.mcyc = 5'(mcyc); e.rd  = 1'(rd);
    e.wr   = 1'(wr);
    return e;
  endfunction

  function automatic ev_t e_ir(int ret, int alu);
    return mk(1, 1, 0, 0, 0, 0, 0, 0, alu, ret, 0, 1, 0);
  endfunction
  function automatic ev_t e_wb(int cyc, int ret, int alu, int mcyc);
    return mk(cyc, 0, 1, 1, 0, 0, 0, 0, alu, ret, mcyc, 0, 0);
  endfunction
  function automatic ev_t e_pc(int cyc, int sel, int ret, int alu);
    return mk(cyc, 0, 0, 1, sel, 0, 0, 0, alu, ret, 0, 0, 0);
  endfunction

  // Memory responder: answers after mem_delay cycles (data) or at once (fetch)
  int   mem_delay  = 0;
  logic mem_hang   = 1'b0;
  logic fetch_hang = 1'b0;
  int   mem_k      = 0;
  always begin
    @(posedge clk);
    #1;
    if (reset || !mem_req) begin
      mem_k     = 0;
      mem_ready = 1'b0;
    end else begin
      if (mem_ready) mem_k = 0;
      mem_ready = ifetch ? (!fetch_hang && mem_k == 0)
                         : (!mem_hang && mem_k == mem_delay);
      mem_k++;
    end
  end

  // Monitor: one line per observed event, compared against the scoreboard
  int   mon_cyc  = 0;
  int   mon_mcyc = 0;
  logic hlt_prev = 1'b0;
  logic mto_prev = 1'b0;
  always @(negedge clk) begin : monitor
    ev_t  got, want;
    logic trig;
    if (reset) begin
      mon_cyc = 0; mon_mcyc = 0; hlt_prev = 1'b0; mto_prev = 1'b0;
    end else begin
      if (ir_load) begin
        mon_cyc = 1; mon_mcyc = 0;
      end else begin
        if (mon_cyc < 255) mon_cyc++;
        if (mem_req && !ifetch) mon_mcyc++;
      end
      trig = ir_load | write_reg | pc_en | illegal_op |
             (halted & !hlt_prev) | (mem_timeout & !mto_prev);
      hlt_prev = halted;
      mto_prev = mem_timeout;
      if (trig) begin
        got = mk(mon_cyc, int'(ir_load), int'(write_reg), int'(pc_en), int'(pc_sel),
                 int'(illegal_op), int'(halted), int'(mem_timeout), int'(alu_inst),
                 int'(retired), mon_mcyc, int'(read_mem), int'(write_mem));
        n_ev++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL ev%0d unexpected: got %h required none", n_ev, got);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL ev%0d: got %h required %h", n_ev, got, want);
          end else begin
            $display("ev%0d ok: cyc=%0d ir=%b wreg=%b pc_en=%b sel=%0d ill=%b hlt=%b mto=%b alu=%0d ret=%0d mcyc=%0d rd=%b wr=%b",
                     n_ev, got.cyc, got.ir, got.wreg, got.pen, got.sel, got.ill, got.hlt,
                     got.mto, got.alu, got.ret, got.mcyc, got.rd, got.wr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("%s ok: %h", name, got);
    end
  endtask

  // Wait (bounded) for the instruction to finish, then step to the next cycle
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (pc_en || halted || mem_timeout) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got no completion required completion", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic imm,
                     input logic br, input int md, input ev_t e1, input ev_t e2);
    opcode = op; imm_flag = imm; branch_taken = br; mem_delay = md;
    sb.push_back(e1);
    sb.push_back(e2);
    wait_done(name);
  endtask

  function automatic logic [31:0] out_vec();
    return {14'd0, mem_req, ifetch, read_mem, write_mem, ir_load, write_reg, pc_en,
            pc_sel, halted, illegal_op, mem_timeout, alu_inst, retired};
  endfunction

  initial begin
    reset = 1'b0; opcode = OP_ADD; imm_flag = 1'b0; branch_taken = 1'b0; resume = 1'b0;
    #1 reset = 1'b1;
    #1 chk("reset_state", out_vec(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run("add", OP_ADD, 0, 0, 0, e_ir(0, 0), e_wb(4, 0, 0, 0));
    run("sub", OP_SUB, 0, 0, 0, e_ir(1, 0), e_wb(4, 1, 1, 0));
    run("sft_r", OP_SFT, 1, 0, 0, e_ir(2, 1), e_wb(4, 2, 3, 0));
    run("dec", OP_INC, 0, 0, 0, e_ir(3, 3), e_wb(4, 3, 5, 0));
    run("beq_taken", OP_BEQ, 0, 1, 0, e_ir(0, 5), e_pc(3, 1, 0, 7));
    run("bne_not", OP_BNE, 0, 0, 0, e_ir(1, 7), e_pc(3, 0, 1, 6));
    run("jmp", OP_JMP, 0, 0, 0, e_ir(2, 6), e_pc(3, 2, 2, 0));
    run("lb_wait3", OP_LB, 0, 0, 3, e_ir(3, 0), e_wb(8, 3, 0, 4));
    run("str", OP_STR, 0, 0, 0, e_ir(0, 0), mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    run("tba", OP_TBA, 0, 0, 0, e_ir(1, 0), mk(3, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));

    // HALT: retired bumps on entry, resume gives a pc_en in the HALT cycle
    opcode = OP_HALT;
    sb.push_back(e_ir(2, 0));
    sb.push_back(mk(4, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0));
    sb.push_back(mk(7, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0));
    wait_done("halt");
    repeat (2) @(posedge clk);
    #1;
    opcode = OP_STR; mem_hang = 1'b1;
    sb.push_back(e_ir(0, 0));
    sb.push_back(mk(19, 0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 0, 0));
    resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    wait_done("str_timeout");

    // ERROR: resume refetches without a PC update, then the store completes
    resume = 1'b1; mem_hang = 1'b0;
    sb.push_back(e_ir(0, 0));
    sb.push_back(mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    @(posedge clk);
    #1 resume = 1'b0;
    wait_done("str_retry");

    // resume held high outside HALT/ERROR must have no effect
    resume = 1'b1;
    run("inc_resume_hi", OP_INC, 1, 0, 0, e_ir(1, 0), e_wb(4, 1, 4, 0));
    resume = 1'b0;

    // LB abandoned by an asynchronous reset in the middle of MEM
    opcode = OP_LB; mem_hang = 1'b1;
    sb.push_back(e_ir(2, 4));
    begin
      bit in_mem = 0;
      for (int i = 0; i < 20 && !in_mem; i++) begin
        @(negedge clk);
        if (read_mem && !ifetch) in_mem = 1;
      end
      chk("reach_mem", 32'(in_mem), 32'd1);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), 32'd0);
    mem_hang = 1'b0; opcode = OP_ADD; imm_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("fetch_after_reset", {27'd0, mem_req, ifetch, read_mem, write_mem, ir_load},
           32'b11100);

    // Four retirements wrap the 2-bit counter back to zero
    for (int r = 0; r < 4; r++) begin
      sb.push_back(e_ir(r, 0));
      sb.push_back(e_wb(4, r, 0, 0));
    end
    for (int r = 0; r < 4; r++) begin
      if (r == 3) begin
        @(negedge clk);
        fetch_hang = 1'b1;
      end
      wait_done("add_wrap");
    end
    chk("retired_wrap", 32'(retired), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
